// File: rtl/step_clock_gen_pkg.sv
// Shared types for the step-clock generator: operating modes and FSM states.
package step_clk_pkg;

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'b00,
        MODE_BURST  = 2'b01,
        MODE_RUN    = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BURST = 2'b01,
        RUN   = 2'b10
    } state_e;

endpackage

// File: rtl/step_clock_gen_button_debounce.sv
// Step-button conditioning: 2-flop synchroniser, debounce counter and a
// single-cycle registered press event on the debounced rising edge.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk_in,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press_evt
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1, sync2, armed, hit;
    logic [CW-1:0] cnt;

    // hit: this sample is the DEBOUNCE_CYCLES-th consecutive high one
    assign hit = sync2 && (cnt >= CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            cnt       <= '0;
            level     <= 1'b0;
            press_evt <= 1'b0;
            armed     <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (!sync2)
                cnt <= '0;
            else if (cnt != CW'(DEBOUNCE_CYCLES))
                cnt <= cnt + CW'(1);
            if (!sync2)
                level <= 1'b0;
            else if (hit)
                level <= 1'b1;
            press_evt <= hit && !level && armed;
            armed     <= armed | !level;
        end
    end

endmodule

// File: rtl/step_clock_gen.sv
// Step-clock generator for the core: debounced button drives single-step,
// N-step burst or free-run stepping; emits a registered one-cycle step_en.
module step_clock_gen
    import step_clk_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DIV_WIDTH       = 16,
    parameter int BURST_WIDTH     = 8,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                   clk_in,
    input  logic                   reset,
    input  logic                   clk_butt,
    input  logic [1:0]             mode,
    input  logic [DIV_WIDTH-1:0]   div_val,
    input  logic [BURST_WIDTH-1:0] burst_len,
    input  logic                   halt,
    output logic                   step_en,
    output logic                   busy,
    output logic [CNT_WIDTH-1:0]   step_count
);
    state_e                 state, nstate;
    mode_e                  mode_s;
    logic                   btn_level, press_evt, press, nstep;
    logic [DIV_WIDTH-1:0]   per_cnt, per_nxt;
    logic [BURST_WIDTH-1:0] rem, rem_nxt;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc (
        .clk_in    (clk_in),
        .reset     (reset),
        .raw       (clk_butt),
        .level     (btn_level),
        .press_evt (press_evt)
    );

    // press_evt only ever fires alongside a freshly-high level
    assign press  = press_evt && btn_level;
    assign mode_s = mode_e'(mode);
    assign busy   = (state != IDLE);

    always_comb begin
        nstate  = state;
        nstep   = 1'b0;
        per_nxt = per_cnt;
        rem_nxt = rem;
        case (state)
            IDLE: if (press) begin
                case (mode_s)
                    MODE_SINGLE: nstep = 1'b1;
                    MODE_BURST: if (burst_len != '0) begin
                        nstep   = 1'b1;
                        per_nxt = div_val;
                        rem_nxt = burst_len - BURST_WIDTH'(1);
                        nstate  = BURST;
                    end
                    MODE_RUN: begin
                        nstep   = 1'b1;
                        per_nxt = div_val;
                        nstate  = RUN;
                    end
                    default: ;
                endcase
            end
            BURST: begin
                // rem counts steps still owed after the ones already issued
                if (mode_s != MODE_BURST || rem == '0)
                    nstate = IDLE;
                else if (per_cnt == '0) begin
                    nstep   = 1'b1;
                    per_nxt = div_val;
                    rem_nxt = rem - BURST_WIDTH'(1);
                end else
                    per_nxt = per_cnt - DIV_WIDTH'(1);
            end
            RUN: begin
                if (mode_s != MODE_RUN || press)
                    nstate = IDLE;
                else if (per_cnt == '0) begin
                    nstep   = 1'b1;
                    per_nxt = div_val;
                end else
                    per_nxt = per_cnt - DIV_WIDTH'(1);
            end
            default: nstate = IDLE;
        endcase
        if (halt) begin
            nstate = IDLE;
            nstep  = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state      <= IDLE;
            step_en    <= 1'b0;
            per_cnt    <= '0;
            rem        <= '0;
            step_count <= '0;
        end else begin
            state      <= nstate;
            step_en    <= nstep;
            per_cnt    <= per_nxt;
            rem        <= rem_nxt;
            step_count <= step_count + CNT_WIDTH'(step_en);
        end
    end

endmodule

// File: tb/tb_step_clock_gen.sv
// Bench for step_clock_gen: directed and randomized presses, expected step
// edges derived from press time, mode, div_val and burst_len.
module tb_step_clock_gen;
    localparam int D = 4;

    logic        clk_in = 1'b0, reset = 1'b0, clk_butt = 1'b0, halt = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [15:0] div_val = '0;
    logic [7:0]  burst_len = '0;
    logic        step_en, busy;
    logic [31:0] step_count;
    logic [31:0] exp_cnt = '0;

    int cyc = 0;
    int steps[$];
    int exp_q[$];
    int n_pass = 0, n_chk = 0;
    bit busy_seen = 0;

    step_clock_gen dut (
        .clk_in(clk_in), .reset(reset), .clk_butt(clk_butt), .mode(mode),
        .div_val(div_val), .burst_len(burst_len), .halt(halt),
        .step_en(step_en), .busy(busy), .step_count(step_count)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    // At a negedge, cyc is the index of the posedge that produced the outputs
    always @(negedge clk_in) begin
        if (step_en) steps.push_back(cyc);
        if (busy) busy_seen = 1'b1;
    end

    task automatic chk(input string tag, input longint obs, input longint expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    endtask

    // p = first edge that samples the button high
    task automatic press(input int hold, output int p);
        @(negedge clk_in);
        clk_butt = 1'b1;
        p = cyc + 1;
        repeat (hold) @(negedge clk_in);
        clk_butt = 1'b0;
    endtask

    task automatic settle(input string tag);
        repeat (30) @(negedge clk_in);
        chk({tag, " nsteps"}, steps.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk({tag, " edge"}, (i < steps.size()) ? steps[i] : -1, exp_q[i]);
        exp_cnt = exp_cnt + 32'(exp_q.size());
        chk({tag, " count"}, step_count, exp_cnt);
        chk({tag, " busy"}, busy, 0);
        steps.delete();
        exp_q.delete();
    endtask

    initial begin
        int p, p2, s0, t, stop, m, d, l;
        // reset state
        repeat (3) @(negedge clk_in);
        chk("rst step_en", step_en, 0);
        chk("rst busy", busy, 0);
        chk("rst count", step_count, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk_in);

        // single step, long hold
        mode = 2'b00; busy_seen = 0;
        press(20, p);
        exp_q.push_back(p + D + 2);
        settle("single");
        chk("single busy_seen", busy_seen, 0);

        // glitchy press never debounces
        @(negedge clk_in); clk_butt = 1'b1;
        repeat (3) @(negedge clk_in); clk_butt = 1'b0;
        @(negedge clk_in); clk_butt = 1'b1;
        repeat (3) @(negedge clk_in); clk_butt = 1'b0;
        settle("glitch");

        // burst of 5, div 2
        mode = 2'b01; burst_len = 8'd5; div_val = 16'd2;
        press(8, p);
        s0 = p + D + 2;
        for (int k = 0; k < 5; k++) exp_q.push_back(s0 + 3 * k);
        while (cyc < s0 + 12) @(negedge clk_in);
        chk("burst busy at last", busy, 1);
        @(negedge clk_in);
        chk("burst busy after", busy, 0);
        settle("burst");

        // free-run every cycle, stopped by second press
        mode = 2'b10; div_val = 16'd0;
        press(6, p);
        repeat (10) @(negedge clk_in);
        press(6, p2);
        stop = p2 + D + 2;
        for (t = p + D + 2; t < stop; t++) exp_q.push_back(t);
        settle("run stop");

        // free-run div 3, halt at the 4th pulse
        div_val = 16'd3;
        press(6, p);
        s0 = p + D + 2;
        while (cyc < s0 + 11) @(negedge clk_in);
        halt = 1'b1;
        @(negedge clk_in);
        chk("halt step_en", step_en, 0);
        chk("halt busy", busy, 0);
        halt = 1'b0;
        for (int k = 0; k < 3; k++) exp_q.push_back(s0 + 4 * k);
        settle("run halt");

        // burst_len 0 issues nothing
        mode = 2'b01; burst_len = 8'd0; busy_seen = 0;
        press(6, p);
        settle("burst0");
        chk("burst0 busy_seen", busy_seen, 0);

        // reset mid-run
        mode = 2'b10; div_val = 16'd1;
        press(6, p);
        repeat (8) @(negedge clk_in);
        reset = 1'b0;
        @(negedge clk_in);
        reset = 1'b1;
        chk("midrst step_en", step_en, 0);
        chk("midrst busy", busy, 0);
        chk("midrst count", step_count, 0);
        steps.delete();
        exp_cnt = '0;
        settle("midrst");

        // randomized trials
        for (int tr = 0; tr < 10; tr++) begin
            m = $urandom_range(0, 3);
            d = $urandom_range(0, 3);
            l = $urandom_range(0, 4);
            mode = 2'(m); div_val = 16'(d); burst_len = 8'(l);
            press($urandom_range(D, 12), p);
            s0 = p + D + 2;
            case (m)
                0: exp_q.push_back(s0);
                1: for (int k = 0; k < l; k++) exp_q.push_back(s0 + k * (d + 1));
                2: begin
                    repeat ($urandom_range(3, 10)) @(negedge clk_in);
                    press($urandom_range(D, 8), p2);
                    stop = p2 + D + 2;
                    for (t = s0; t < stop; t += d + 1) exp_q.push_back(t);
                end
                default: ;
            endcase
            settle($sformatf("rand%0d m%0d", tr, m));
        end

        // counter wrap
        mode = 2'b00;
        @(negedge clk_in);
        force dut.step_count = 32'hFFFF_FFFF;
        #1 release dut.step_count;
        exp_cnt = 32'hFFFF_FFFF;
        @(negedge clk_in);
        chk("wrap preload", step_count, 32'hFFFF_FFFF);
        press(6, p);
        exp_q.push_back(p + D + 2);
        settle("wrap");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
